lcd_bus_arbiter: RTL

- Shares one HD44780 4-bit LCD bus (en, rs, data[3:0]) between NUM_REQ requesters, e.g. the power-up init sequencer, the text writer and the clock display.
- Each requester offers one byte, or one raw nibble, per valid/ready handshake.
- The arbiter picks a winner round-robin, serialises the transfer into nibbles with en pulses, and then holds the bus idle for the settle time the command needs.
- A lock bit lets one requester keep the bus for a multi-byte sequence, such as cursor-address then 8 characters.

---
 rtl/lcd_pkg.sv | 35 +++
 rtl/lcd_rr_arbiter.sv | 58 +++++
 rtl/lcd_bus_arbiter.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/lcd_pkg.sv
`default_nettype none
// ============================================================================
//  Module     : lcd_pkg
//  Description: Shared types, HD44780 command bytes and helpers for the LCD
//               bus arbiter.
//  Revision   : 1.0 - initial release
// ============================================================================
package lcd_pkg;

  // Bus sequencer states
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_HI_SET = 3'd1,
    S_HI_CLR = 3'd2,
    S_LO_SET = 3'd3,
    S_LO_CLR = 3'd4,
    S_WAIT   = 3'd5
  } lcd_state_e;

  // HD44780 command bytes
  localparam logic [7:0] c_CMD_CLEAR   = 8'h01;
  localparam logic [7:0] c_CMD_HOME    = 8'h02;
  localparam logic [7:0] c_CMD_FUNCSET = 8'h28;
  localparam logic [7:0] c_CMD_DISPCTL = 8'h0C;
  localparam logic [7:0] c_CMD_ENTRY   = 8'h06;
  localparam logic [7:0] c_CMD_DDRAM   = 8'h80;

  // Clear and home are the only commands with the long execution time:
  // they are command writes whose upper six bits are all zero.
  function automatic logic is_long_cmd(input logic i_rs, input logic [7:0] i_byte);
    return (!i_rs) && ((i_byte & 8'hFC) == 8'h00);
  endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module     : lcd_rr_arbiter
//  Description: Combinational round-robin picker. Grants the first eligible
//               index at or after the pointer, wrapping modulo NUM_REQ.
//  Revision   : 1.0 - initial release
// ============================================================================
module lcd_rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = 1
) (
  input  logic [NUM_REQ-1:0] i_elig,
  input  logic [PTR_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_grant
);

  localparam logic [PTR_W:0] c_NUM = (PTR_W+1)'(NUM_REQ);

  logic [PTR_W:0] w_ptr;
  logic [PTR_W:0] w_dist [NUM_REQ];
  logic [PTR_W:0] w_best;
  logic           w_found;

  assign w_ptr = {1'b0, i_ptr};

  // Distance of each requester from the pointer, going forward with wrap
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if ((PTR_W+1)'(i) >= w_ptr) begin
        w_dist[i] = (PTR_W+1)'(i) - w_ptr;
      end else begin
        w_dist[i] = (PTR_W+1)'(i) + c_NUM - w_ptr;
      end
    end
  end

  // Smallest distance among eligible requesters
  always_comb begin
    w_best  = '0;
    w_found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (i_elig[i] && (!w_found || (w_dist[i] < w_best))) begin
        w_best  = w_dist[i];
        w_found = 1'b1;
      end
    end
  end

  // Distances are unique, so exactly one eligible index matches the best one
  always_comb begin
    o_grant = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      o_grant[i] = w_found && i_elig[i] && (w_dist[i] == w_best);
    end
  end

endmodule
`default_nettype wire

// File: rtl/lcd_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module     : lcd_bus_arbiter
//  Description: Shares one HD44780 4-bit bus between NUM_REQ requesters.
//               Round-robin grant, nibble serialisation with en pulses,
//               per-command settle time and an optional bus lock.
//  Revision   : 1.0 - initial release
// ============================================================================
module lcd_bus_arbiter
  import lcd_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int SHORT_WAIT  = 0,
  parameter int LONG_WAIT   = 2,
  parameter int NIBBLE_WAIT = 5,
  parameter int WAIT_W      = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_rs,
  input  logic [NUM_REQ-1:0]   req_nibble,
  input  logic [NUM_REQ-1:0]   req_lock,
  output logic                 en,
  output logic                 rs,
  output logic [3:0]           data,
  output logic                 busy
);

  localparam int PTR_W = (NUM_REQ > 2) ? 2 : 1;

  localparam logic [WAIT_W-1:0] c_SHORT_WAIT  = WAIT_W'(SHORT_WAIT);
  localparam logic [WAIT_W-1:0] c_LONG_WAIT   = WAIT_W'(LONG_WAIT);
  localparam logic [WAIT_W-1:0] c_NIBBLE_WAIT = WAIT_W'(NIBBLE_WAIT);

  lcd_state_e        r_state;
  logic [PTR_W-1:0]  r_ptr;
  logic              r_locked;
  logic [PTR_W-1:0]  r_owner;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [WAIT_W-1:0] r_wait_val;
  logic              r_nib;
  logic [3:0]        r_lo;
  logic              r_en;
  logic              r_rs;
  logic [3:0]        r_data;

  logic [NUM_REQ-1:0] w_owner_oh;
  logic [NUM_REQ-1:0] w_elig;
  logic [NUM_REQ-1:0] w_grant;
  logic [PTR_W-1:0]   w_gidx;
  logic [PTR_W-1:0]   w_next_ptr;
  logic [7:0]         w_sel_byte;
  logic               w_sel_rs;
  logic               w_sel_nib;
  logic               w_sel_lock;
  logic [WAIT_W-1:0]  w_sel_wait;
  logic               w_accept;

  // One-hot mask of the lock owner
  always_comb begin
    w_owner_oh = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_owner_oh[i] = (r_owner == PTR_W'(i));
    end
  end

  // While locked only the owner may compete, even if it is not requesting
  assign w_elig = r_locked ? (req_valid & w_owner_oh) : req_valid;

  lcd_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr (
    .i_elig  (w_elig),
    .i_ptr   (r_ptr),
    .o_grant (w_grant)
  );

  // Mux the winning requester's transfer fields out of the flat buses
  always_comb begin
    w_sel_byte = '0;
    w_sel_rs   = 1'b0;
    w_sel_nib  = 1'b0;
    w_sel_lock = 1'b0;
    w_gidx     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_sel_byte = w_sel_byte | req_data[8*i +: 8];
        w_sel_rs   = w_sel_rs   | req_rs[i];
        w_sel_nib  = w_sel_nib  | req_nibble[i];
        w_sel_lock = w_sel_lock | req_lock[i];
        w_gidx     = w_gidx     | PTR_W'(i);
      end
    end
  end

  // Settle time the accepted transfer will need after its last en pulse
  always_comb begin
    if (w_sel_nib) begin
      w_sel_wait = c_NIBBLE_WAIT;
    end else if (is_long_cmd(w_sel_rs, w_sel_byte)) begin
      w_sel_wait = c_LONG_WAIT;
    end else begin
      w_sel_wait = c_SHORT_WAIT;
    end
  end

  assign w_next_ptr = (w_gidx == PTR_W'(NUM_REQ - 1)) ? '0 : (w_gidx + PTR_W'(1));
  assign w_accept   = (r_state == S_IDLE) && (|w_grant);

  // Ready is only offered in IDLE and is suppressed while reset is asserted
  assign req_ready = ((r_state == S_IDLE) && reset_n) ? w_grant : '0;

  // Bus sequencer: accept, two nibbles (or one), then the settle wait
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_ptr      <= '0;
      r_locked   <= 1'b0;
      r_owner    <= '0;
      r_wait_cnt <= '0;
      r_wait_val <= '0;
      r_nib      <= 1'b0;
      r_lo       <= '0;
      r_en       <= 1'b0;
      r_rs       <= 1'b0;
      r_data     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_lo       <= w_sel_byte[3:0];
            r_nib      <= w_sel_nib;
            r_wait_val <= w_sel_wait;
            r_rs       <= w_sel_rs;
            r_data     <= w_sel_byte[7:4];
            r_en       <= 1'b1;
            r_ptr      <= w_next_ptr;
            r_locked   <= w_sel_lock;
            r_owner    <= w_sel_lock ? w_gidx : '0;
            r_state    <= S_HI_SET;
          end
        end
        S_HI_SET: begin
          r_en    <= 1'b0;
          r_state <= S_HI_CLR;
        end
        S_HI_CLR: begin
          if (r_nib) begin
            r_wait_cnt <= r_wait_val;
            r_state    <= (r_wait_val == '0) ? S_IDLE : S_WAIT;
          end else begin
            r_en    <= 1'b1;
            r_data  <= r_lo;
            r_state <= S_LO_SET;
          end
        end
        S_LO_SET: begin
          r_en    <= 1'b0;
          r_state <= S_LO_CLR;
        end
        S_LO_CLR: begin
          r_wait_cnt <= r_wait_val;
          r_state    <= (r_wait_val == '0) ? S_IDLE : S_WAIT;
        end
        S_WAIT: begin
          if (r_wait_cnt <= WAIT_W'(1)) begin
            r_wait_cnt <= '0;
            r_state    <= S_IDLE;
          end else begin
            r_wait_cnt <= r_wait_cnt - WAIT_W'(1);
          end
        end
        default: begin
          r_en    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign en   = r_en;
  assign rs   = r_rs;
  assign data = r_data;
  assign busy = (r_state != S_IDLE);

endmodule
`default_nettype wire
